param_queue: RTL and testbench

//   Parametrised ready/valid FIFO; generalises the fixed 1-deep, 1-bit queue to any width and depth.

---
 rtl/param_queue.sv | 118 +++++++++++
 tb/tb_param_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_queue.sv
// param_queue -- parametrised ready/valid FIFO used as the decoupling buffer
// between a producer and a consumer.
//
// Parameters
//   WIDTH     data bits per entry
//   DEPTH     number of entries (any value >= 1, not restricted to 2^n)
//   FLOW      1: an empty queue passes enq data straight to deq in the same cycle
//   PIPE      1: a full queue accepts an enq in the same cycle as a deq
//   AF_LEVEL  io_almost_full threshold on io_count (0 disables the flag)
//
// Ports
//   clk, reset                     clock; asynchronous active-high reset
//   io_enq_valid/ready/bits        producer side handshake and data
//   io_deq_valid/ready/bits        consumer side handshake and data
//   io_count                       occupancy 0..DEPTH
//   io_flush                       synchronous discard of all entries
//   io_almost_full                 io_count >= AF_LEVEL
module param_queue #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter bit          FLOW     = 1'b0,
    parameter bit          PIPE     = 1'b0,
    parameter int unsigned AF_LEVEL = 3,
    localparam int unsigned CW      = $clog2(DEPTH + 1),
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [CW-1:0]    io_count,
    input  logic             io_flush,
    output logic             io_almost_full
);

    logic [WIDTH-1:0] ram_q [DEPTH];
    logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;

    logic ptr_match, empty, full;
    logic do_flow, do_enq, do_deq;

    // Pointer increment with an explicit wrap at DEPTH-1, so non-power-of-2
    // depths never index past the last entry. DEPTH=1 pins the pointer at 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1) return '0;
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match &  maybe_full_q;

    // Handshake outputs are held low while reset is asserted so that a
    // FLOW/PIPE bypass cannot advertise a transfer during reset.
    assign io_enq_ready = ~reset & ~io_flush & (~full  | (PIPE & io_deq_ready));
    assign io_deq_valid = ~reset & ~io_flush & (~empty | (FLOW & io_enq_valid));
    assign io_deq_bits  = (FLOW & empty) ? io_enq_bits : ram_q[deq_ptr_q];

    // Flow-through moves data without touching storage, so it suppresses
    // both the enqueue and the dequeue bookkeeping.
    assign do_flow = FLOW & empty & io_enq_valid & io_deq_ready;
    assign do_enq  = io_enq_ready & io_enq_valid & ~do_flow;
    assign do_deq  = io_deq_ready & io_deq_valid & ~do_flow;

    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (io_flush) begin
            enq_ptr_d    = '0;
            deq_ptr_d    = '0;
            maybe_full_d = 1'b0;
        end else begin
            if (do_enq) enq_ptr_d = ptr_inc(enq_ptr_q);
            if (do_deq) deq_ptr_d = ptr_inc(deq_ptr_q);
            // Only an unbalanced cycle can change full/empty disambiguation.
            if (do_enq != do_deq) maybe_full_d = do_enq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_enq) ram_q[enq_ptr_q] <= io_enq_bits;
    end

    // Occupancy: (enq - deq) mod DEPTH, with ptr_match resolved by maybe_full.
    logic [CW-1:0] enq_w, deq_w;
    assign enq_w = CW'(enq_ptr_q);
    assign deq_w = CW'(deq_ptr_q);

    always_comb begin
        io_count = '0;
        if (full)                 io_count = CW'(DEPTH);
        else if (enq_w >= deq_w)  io_count = enq_w - deq_w;
        else                      io_count = CW'(DEPTH) - deq_w + enq_w;
    end

    assign io_almost_full = (AF_LEVEL != 0) && (32'(io_count) >= AF_LEVEL);

endmodule

// File: tb/tb_param_queue.sv
module tb_param_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       enq_valid, deq_ready, flush;
    logic [7:0] enq_bits;

    always #5 clk = ~clk;

    // Instance A: WIDTH=8 DEPTH=4 plain queue, AF_LEVEL=3
    logic       a_ev, a_dr, a_fl, a_enq_ready, a_deq_valid, a_af;
    logic [7:0] a_deq_bits;
    logic [2:0] a_count;
    assign a_ev = enq_valid & ~sel;
    assign a_dr = deq_ready & ~sel;
    assign a_fl = flush & ~sel;

    param_queue #(.WIDTH(8), .DEPTH(4), .FLOW(1'b0), .PIPE(1'b0), .AF_LEVEL(3)) u_a (
        .clk(clk), .reset(rst),
        .io_enq_valid(a_ev), .io_enq_ready(a_enq_ready), .io_enq_bits(enq_bits),
        .io_deq_valid(a_deq_valid), .io_deq_ready(a_dr), .io_deq_bits(a_deq_bits),
        .io_count(a_count), .io_flush(a_fl), .io_almost_full(a_af)
    );

    // Instance B: DEPTH=3 with flow-through and pipe, AF_LEVEL=2
    logic       b_ev, b_dr, b_fl, b_enq_ready, b_deq_valid, b_af;
    logic [7:0] b_deq_bits;
    logic [2:0] b_count;
    assign b_ev = enq_valid & sel;
    assign b_dr = deq_ready & sel;
    assign b_fl = flush & sel;

    param_queue #(.WIDTH(8), .DEPTH(3), .FLOW(1'b1), .PIPE(1'b1), .AF_LEVEL(2)) u_b (
        .clk(clk), .reset(rst),
        .io_enq_valid(b_ev), .io_enq_ready(b_enq_ready), .io_enq_bits(enq_bits),
        .io_deq_valid(b_deq_valid), .io_deq_ready(b_dr), .io_deq_bits(b_deq_bits),
        .io_count(b_count), .io_flush(b_fl), .io_almost_full(b_af)
    );

    logic       enq_ready, deq_valid, af;
    logic [7:0] deq_bits;
    logic [2:0] count;
    assign enq_ready = sel ? b_enq_ready : a_enq_ready;
    assign deq_valid = sel ? b_deq_valid : a_deq_valid;
    assign deq_bits  = sel ? b_deq_bits  : a_deq_bits;
    assign count     = sel ? b_count     : a_count;
    assign af        = sel ? b_af        : a_af;

    logic [7:0] sb [$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic       last_acc;
    int         sent;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge with inputs already driven. Samples the handshake
    // shortly before the posedge, updates the scoreboard, returns at the next negedge.
    task automatic tick();
        logic [7:0] e;
        int         depth;
        depth    = sel ? 3 : 4;
        last_acc = 1'b0;
        #3;
        if (rst) begin
            sb.delete();
        end else begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("count_max", 32'(32'(count) <= depth), 32'd1);
            if (flush) begin
                chk("flush_enq_rdy", 32'(enq_ready), 32'd0);
                chk("flush_deq_vld", 32'(deq_valid), 32'd0);
                sb.delete();
            end else begin
                // Push before pop so a flow-through transfer finds its own entry.
                if (enq_valid && enq_ready) begin
                    sb.push_back(enq_bits);
                    last_acc = 1'b1;
                end
                if (deq_valid && deq_ready) begin
                    if (sb.size() == 0) chk("deq_extra", 32'(deq_valid), 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("deq_data", 32'(deq_bits), 32'(e));
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drv(input logic ev, input logic [7:0] bits, input logic dr);
        enq_valid = ev;
        enq_bits  = bits;
        deq_ready = dr;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 1'b0; flush = 1'b0;
        drv(1'b0, 8'h00, 1'b0);

        // reset values while reset is held
        @(posedge clk); #2;
        enq_valid = 1'b1; deq_ready = 1'b1; #1;
        chk("rst_enq_rdy", 32'(enq_ready), 32'd0);
        chk("rst_deq_vld", 32'(deq_valid), 32'd0);
        chk("rst_count",   32'(count),     32'd0);
        chk("rst_af",      32'(af),        32'd0);
        drv(1'b0, 8'h00, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_enq_rdy", 32'(enq_ready), 32'd1);
        chk("post_rst_deq_vld", 32'(deq_valid), 32'd0);

        // fill DEPTH=4 with no consumer, almost_full boundary at 3
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
            tick();
            chk("af_fill", 32'(af), 32'(i + 1 >= 3));
        end
        enq_valid = 1'b0; #1;
        chk("full_enq_rdy", 32'(enq_ready), 32'd0);
        chk("full_count",   32'(count),     32'd4);
        chk("full_af",      32'(af),        32'd1);
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("drained_count", 32'(count),     32'd0);
        chk("drained_vld",   32'(deq_valid), 32'd0);
        chk("drained_af",    32'(af),        32'd0);

        // mixed random traffic
        for (int i = 0; i < 40; i++) begin
            drv(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        drv(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("rand_leftover", 32'(sb.size()), 32'd0);

        // flush with two entries and a competing enqueue
        drv(1'b1, 8'hF1, 1'b0); tick();
        drv(1'b1, 8'hF2, 1'b0); tick();
        flush = 1'b1; drv(1'b1, 8'h99, 1'b0); #1;
        chk("flush_enq_rdy0", 32'(enq_ready), 32'd0);
        chk("flush_deq_vld0", 32'(deq_valid), 32'd0);
        tick();
        flush = 1'b0; enq_valid = 1'b0; #1;
        chk("post_flush_count", 32'(count),     32'd0);
        chk("post_flush_vld",   32'(deq_valid), 32'd0);
        drv(1'b1, 8'h5A, 1'b0); tick();
        drv(1'b0, 8'h00, 1'b1); tick();

        // asynchronous reset in the middle of a cycle with count=3
        drv(1'b1, 8'hC1, 1'b0); tick();
        drv(1'b1, 8'hC2, 1'b0); tick();
        drv(1'b1, 8'hC3, 1'b0); tick();
        enq_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rst = 1'b1; #1;
        chk("async_enq_rdy", 32'(enq_ready), 32'd0);
        chk("async_deq_vld", 32'(deq_valid), 32'd0);
        chk("async_count",   32'(count),     32'd0);
        chk("async_af",      32'(af),        32'd0);
        sb.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0; #1;
        chk("rel_count",   32'(count),     32'd0);
        chk("rel_enq_rdy", 32'(enq_ready), 32'd1);
        chk("rel_deq_vld", 32'(deq_valid), 32'd0);
        drv(1'b1, 8'h77, 1'b0); tick();
        drv(1'b0, 8'h00, 1'b1); tick();

        // DEPTH=3, FLOW=1, PIPE=1 instance
        sel = 1'b1;
        drv(1'b1, 8'hA5, 1'b1); #1;
        chk("flow_vld",   32'(deq_valid), 32'd1);
        chk("flow_bits",  32'(deq_bits),  32'hA5);
        chk("flow_count", 32'(count),     32'd0);
        tick();
        enq_valid = 1'b0; #1;
        chk("flow_after_count", 32'(count),     32'd0);
        chk("flow_after_vld",   32'(deq_valid), 32'd0);

        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 8'(8'h31 + i), 1'b0);
            tick();
            chk("b_af_fill", 32'(af), 32'(i + 1 >= 2));
        end
        enq_valid = 1'b0; #1;
        chk("b_full_count",   32'(count),     32'd3);
        chk("b_full_enq_rdy", 32'(enq_ready), 32'd0);
        drv(1'b1, 8'h34, 1'b1); #1;
        chk("pipe_enq_rdy", 32'(enq_ready), 32'd1);
        tick();
        #1;
        chk("pipe_count", 32'(count), 32'd3);

        // remaining traffic up to 7 entries total, crossing the 2->0 wrap
        sent = 4;
        for (int i = 0; i < 12; i++) begin
            drv(1'(sent < 7), 8'(8'h30 + sent + 1), 1'(i % 3 != 0));
            tick();
            if (last_acc) sent++;
        end
        drv(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("b_sent",       32'(sent),      32'd7);
        chk("b_end_count",  32'(count),     32'd0);
        chk("b_leftover",   32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
